// File: rtl/nonogram_pkg.sv
// Shared types for the board output path: sequencer state encoding and frame header byte.
package nonogram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_TX,
        FINISH,
        HDR,
        CHK
    } state_t;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

endpackage

// File: rtl/board_tx_sequencer.sv
// Streams board BRAM bytes 0..NUM_BYTES-1 to uart_tx, one byte per tx_done handshake.
// Define TX_FRAME_EN to wrap each transfer in an A5 header byte and an XOR checksum byte.
module board_tx_sequencer
    import nonogram_pkg::*;
#(
    parameter int NUM_BYTES    = 100,
    parameter int ADDR_WIDTH   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [7:0]            bram_rdata,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_done
);

    localparam int                    LAT_W     = $clog2(BRAM_LATENCY + 1);
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(BRAM_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BYTES - 1);

    state_t                  state, state_d;
    logic [LAT_W-1:0]        lat_cnt, lat_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [7:0]              data_d;
    logic                    valid_d, busy_d, done_d;
`ifdef TX_FRAME_EN
    logic [7:0]              csum, csum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            bram_addr <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef TX_FRAME_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_d;
            lat_cnt   <= lat_d;
            bram_addr <= addr_d;
            tx_data   <= data_d;
            tx_valid  <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef TX_FRAME_EN
            csum      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        lat_d   = lat_cnt;
        addr_d  = bram_addr;
        data_d  = tx_data;
        valid_d = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef TX_FRAME_EN
        csum_d  = csum;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    addr_d = '0;
                    lat_d  = '0;
`ifdef TX_FRAME_EN
                    csum_d  = '0;
                    state_d = HDR;
`else
                    state_d = READ;
`endif
                end
            end
            READ: begin
                // Capture one edge after rdata settles, so the byte lands BRAM_LATENCY+1 cycles after the address.
                if (lat_cnt == LAT_LAST) begin
                    data_d  = bram_rdata;
                    valid_d = 1'b1;
`ifdef TX_FRAME_EN
                    csum_d  = csum ^ bram_rdata;
`endif
                    state_d = WAIT_TX;
                end else begin
                    lat_d = lat_cnt + LAT_W'(1);
                end
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (bram_addr == LAST_ADDR) begin
`ifdef TX_FRAME_EN
                        lat_d   = '0;
                        state_d = CHK;
`else
                        state_d = FINISH;
`endif
                    end else begin
                        addr_d  = bram_addr + ADDR_WIDTH'(1);
                        lat_d   = '0;
                        state_d = READ;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = IDLE;
            end
`ifdef TX_FRAME_EN
            // lat_cnt doubles as a sent flag while waiting on the header/checksum byte.
            HDR: begin
                if (lat_cnt == '0) begin
                    data_d  = FRAME_HEADER;
                    valid_d = 1'b1;
                    lat_d   = LAT_W'(1);
                end else if (tx_done) begin
                    lat_d   = '0;
                    state_d = READ;
                end
            end
            CHK: begin
                if (lat_cnt == '0) begin
                    data_d  = csum;
                    valid_d = 1'b1;
                    lat_d   = LAT_W'(1);
                end else if (tx_done) begin
                    lat_d   = '0;
                    state_d = FINISH;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_board_tx_sequencer.sv
// Directed bench: three sequencers (BRAM latency 1, 2, 3) with BRAM and uart_tx models.
`timescale 1ns/1ps
module tb_board_tx_sequencer;

    localparam int NB = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] start, busy, done, tx_valid, tx_done, inject;
    logic [AW-1:0] bram_addr [3];
    logic [7:0]    bram_rdata [3];
    logic [7:0]    tx_data [3];
    logic [7:0]    mem [NB];
    logic [7:0]    sent [3][128];
    int nsent [3] = '{0, 0, 0};
    int ndone [3] = '{0, 0, 0};
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int L = g + 1;
        logic [7:0] pipe [L];
        logic [3:0] cnt;
        logic       model_done;

        board_tx_sequencer #(.NUM_BYTES(NB), .BRAM_LATENCY(L)) dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .bram_addr  (bram_addr[g]),
            .bram_rdata (bram_rdata[g]),
            .tx_valid   (tx_valid[g]),
            .tx_data    (tx_data[g]),
            .tx_done    (tx_done[g])
        );

        always @(posedge clk) begin
            pipe[0] <= mem[bram_addr[g]];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign bram_rdata[g] = pipe[L-1];

        // uart_tx stand-in: done pulse 10 cycles after the valid pulse
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt        <= 4'd0;
                model_done <= 1'b0;
            end else begin
                model_done <= 1'b0;
                if (tx_valid[g]) cnt <= 4'd9;
                else if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) model_done <= 1'b1;
                end
            end
        end
        assign tx_done[g] = model_done | inject[g];

        always @(posedge clk) begin
            #1;
            if (tx_valid[g] && nsent[g] < 128) begin
                sent[g][nsent[g]] = tx_data[g];
                nsent[g]++;
            end
            if (done[g]) ndone[g]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; chained returns at the negedge where done is high.
    task automatic run_xfer(input int g, input bit chained, input int poke, input string tag);
        logic [7:0] exp [8];
        logic [7:0] cs;
        int nexp, base, dbase, lat, cyc, exp_lat;
        nexp = 0;
        cs = 8'h00;
`ifdef TX_FRAME_EN
        exp[0] = 8'hA5;
        nexp = 1;
        exp_lat = 1;
`else
        exp_lat = g + 2;
`endif
        for (int i = 0; i < NB; i++) begin
            exp[nexp] = mem[i];
            nexp++;
            cs = cs ^ mem[i];
        end
`ifdef TX_FRAME_EN
        exp[nexp] = cs;
        nexp++;
`endif
        base  = nsent[g];
        dbase = ndone[g];
        start[g] = 1'b1;
        @(posedge clk);
        #1;
        start[g] = 1'b0;
        lat = 0;
        while (!tx_valid[g] && lat < 50) begin
            inject[g] = (poke == 2) && (lat == 0);
            @(posedge clk);
            #1;
            lat++;
        end
        inject[g] = 1'b0;
        check({tag, " first_valid_latency"}, lat, exp_lat);
        if (poke == 1) begin
            @(negedge clk);
            start[g] = 1'b1;
            @(negedge clk);
            start[g] = 1'b0;
        end
        cyc = 0;
        while (!done[g] && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " done"}, done[g], 1);
        check({tag, " busy_at_done"}, busy[g], 0);
        check({tag, " addr_at_done"}, bram_addr[g], 0);
        check({tag, " byte_count"}, nsent[g] - base, nexp);
        for (int i = 0; i < nexp; i++)
            if (base + i < nsent[g])
                check($sformatf("%s byte%0d", tag, i), sent[g][base+i], exp[i]);
        if (!chained) begin
            repeat (3) @(negedge clk);
            check({tag, " done_pulses"}, ndone[g] - dbase, 1);
            check({tag, " busy_after"}, busy[g], 0);
        end
    endtask

    initial begin
        int base, cyc;
        start  = '0;
        inject = '0;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        repeat (3) @(negedge clk);
        check("reset busy", busy[1], 0);
        check("reset done", done[1], 0);
        check("reset tx_valid", tx_valid[1], 0);
        check("reset tx_data", tx_data[1], 0);
        check("reset addr", bram_addr[1], 0);
        rst = 1'b0;
        @(negedge clk);

        run_xfer(1, 1'b0, 0, "basic");

        inject[1] = 1'b1;
        @(negedge clk);
        inject[1] = 1'b0;
        base = nsent[1];
        repeat (2) @(negedge clk);
        check("idle_txdone busy", busy[1], 0);
        check("idle_txdone bytes", nsent[1] - base, 0);
        check("idle_txdone addr", bram_addr[1], 0);

        run_xfer(1, 1'b0, 1, "ignore_start");

        base = nsent[1];
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        cyc = 0;
        while (nsent[1] - base < 2 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midrst second_valid_seen", nsent[1] - base, 2);
        rst = 1'b1;
        #1;
        check("midrst busy", busy[1], 0);
        check("midrst addr", bram_addr[1], 0);
        check("midrst tx_valid", tx_valid[1], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_xfer(1, 1'b0, 0, "after_rst");

        run_xfer(1, 1'b1, 0, "b2b_first");
        run_xfer(1, 1'b0, 0, "b2b_second");

        run_xfer(0, 1'b0, 0, "lat1");
        run_xfer(2, 1'b0, 2, "lat3");

        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
        run_xfer(1, 1'b0, 0, "pattern2");
        run_xfer(2, 1'b0, 0, "pattern2_lat3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
